ofdm_symbol_framer: RTL and testbench

OFDM_SYMBOL_FRAMER -- requirements
Module: ofdm_symbol_framer

---
 rtl/ofdm_symbol_framer_pkg.sv | 27 ++
 rtl/ofdm_symbol_framer_if.sv | 19 +
 rtl/ofdm_symbol_framer_axis_out_reg.sv | 66 ++++++
 rtl/ofdm_symbol_framer.sv | 167 ++++++++++++++++
 tb/tb_ofdm_symbol_framer.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ofdm_symbol_framer_pkg.sv
// Shared constants, state encoding and sample type for the OFDM symbol framer (package csi_pkg).
package csi_pkg;

    localparam int FFT_LEN     = 64;
    localparam int DATA_CP_LEN = 16;
    localparam int LTF_GI_LEN  = 32;
    localparam int LTF_SYMBOLS = 2;
    localparam int LTF_LEN     = FFT_LEN * LTF_SYMBOLS;
    localparam int CNT_W       = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LTF_GI,
        ST_LTF,
        ST_DATA_CP,
        ST_DATA
    } framer_state_e;

    typedef logic [31:0]      sample_t;
    typedef logic [CNT_W-1:0] cnt_t;

    // Terminal-count value for a region of the given length.
    function automatic cnt_t last_idx(input int len);
        return cnt_t'(len - 1);
    endfunction

endpackage

// File: rtl/ofdm_symbol_framer_if.sv
// AXI-Stream style master/slave bundle for the framed sample output.
// The tuser field exists only when FRAMER_SYMBOL_INDEX_EN is defined.
interface ofdm_symbol_framer_if #(
    parameter int DATA_W = 32
);
    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic              tlast;
`ifdef FRAMER_SYMBOL_INDEX_EN
    logic [3:0]        tuser;

    modport master (output tvalid, output tdata, output tlast, output tuser, input tready);
    modport slave  (input tvalid, input tdata, input tlast, input tuser, output tready);
`else
    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
`endif
endinterface

// File: rtl/ofdm_symbol_framer_axis_out_reg.sv
// Single-entry output register with valid/ready hold for the framer output stream.
// Carries the symbol index field when FRAMER_SYMBOL_INDEX_EN is defined.
module axis_out_reg #(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              last_i,
`ifdef FRAMER_SYMBOL_INDEX_EN
    input  logic [3:0]        user_i,
`endif
    ofdm_symbol_framer_if.master m_if
);
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic [DATA_W-1:0] data_q, data_d;

    // load_i can only be asserted while the slot is free or draining, so hold is implicit.
    always_comb begin
        valid_d = valid_q;
        last_d  = last_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            last_d  = last_i;
            data_d  = data_i;
        end else if (m_if.tready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            last_q  <= last_d;
            data_q  <= data_d;
        end
    end

    assign m_if.tvalid = valid_q;
    assign m_if.tlast  = last_q;
    assign m_if.tdata  = data_q;

`ifdef FRAMER_SYMBOL_INDEX_EN
    logic [3:0] user_q, user_d;

    always_comb begin
        user_d = user_q;
        if (load_i) user_d = user_i;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) user_q <= '0;
        else          user_q <= user_d;
    end

    assign m_if.tuser = user_q;
`endif

endmodule

// File: rtl/ofdm_symbol_framer.sv
// OFDM symbol framer: drops the LTF guard interval and data cyclic prefixes, forwards 64-sample symbols.
// Optional FRAMER_SYMBOL_INDEX_EN adds m00_axis_tuser carrying the symbol index.
module ofdm_symbol_framer
    import csi_pkg::*;
#(
    parameter int NUM_DATA_SYMBOLS = 4,
    parameter int SAMPLE_W         = 32
) (
    input  logic                s00_axis_aclk,
    input  logic                s00_axis_aresetn,
    input  logic                s00_axis_tvalid,
    input  logic [SAMPLE_W-1:0] s00_axis_tdata,
    input  logic                s00_axis_tuser,
    output logic                s00_axis_tready,
    output logic                m00_axis_tvalid,
    output logic [SAMPLE_W-1:0] m00_axis_tdata,
    output logic                m00_axis_tlast,
    input  logic                m00_axis_tready,
`ifdef FRAMER_SYMBOL_INDEX_EN
    output logic [3:0]          m00_axis_tuser,
`endif
    output logic                busy,
    output logic                resync_pulse
);
    // state   | meaning
    // IDLE    | waiting for sync, beats dropped
    // LTF_GI  | dropping the rest of the 32-sample LTF guard interval
    // LTF     | forwarding the two 64-sample LTF symbols
    // DATA_CP | dropping a 16-sample cyclic prefix
    // DATA    | forwarding one 64-sample data symbol

    localparam int SYM_W = (NUM_DATA_SYMBOLS > 0) ? $clog2(NUM_DATA_SYMBOLS + 1) : 1;
    localparam logic [SYM_W-1:0] SYM_LAST =
        SYM_W'((NUM_DATA_SYMBOLS > 0) ? NUM_DATA_SYMBOLS - 1 : 0);
    localparam framer_state_e AFTER_LTF = (NUM_DATA_SYMBOLS == 0) ? ST_IDLE : ST_DATA_CP;

    framer_state_e    state_q, state_d;
    cnt_t             cnt_q, cnt_d;
    logic [SYM_W-1:0] sym_q, sym_d;
    logic             resync_q, resync_d;
    logic             beat;
    logic             fwd;
    logic             fwd_last;

    ofdm_symbol_framer_if #(.DATA_W(SAMPLE_W)) m_if ();

    assign s00_axis_tready = m00_axis_tready || !m_if.tvalid;
    assign beat            = s00_axis_tvalid && s00_axis_tready;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sym_d    = sym_q;
        resync_d = 1'b0;
        fwd      = 1'b0;
        fwd_last = 1'b0;
        if (beat) begin
            if (s00_axis_tuser) begin
                // Sync sample itself counts as guard-interval sample 0.
                resync_d = (state_q != ST_IDLE);
                state_d  = ST_LTF_GI;
                cnt_d    = cnt_t'(1);
                sym_d    = '0;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        state_d = ST_IDLE;
                    end
                    ST_LTF_GI: begin
                        if (cnt_q == last_idx(LTF_GI_LEN)) begin
                            state_d = ST_LTF;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + cnt_t'(1);
                        end
                    end
                    ST_LTF: begin
                        fwd      = 1'b1;
                        fwd_last = (cnt_q == last_idx(FFT_LEN)) || (cnt_q == last_idx(LTF_LEN));
                        if (cnt_q == last_idx(LTF_LEN)) begin
                            state_d = AFTER_LTF;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + cnt_t'(1);
                        end
                    end
                    ST_DATA_CP: begin
                        if (cnt_q == last_idx(DATA_CP_LEN)) begin
                            state_d = ST_DATA;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + cnt_t'(1);
                        end
                    end
                    ST_DATA: begin
                        fwd      = 1'b1;
                        fwd_last = (cnt_q == last_idx(FFT_LEN));
                        if (cnt_q == last_idx(FFT_LEN)) begin
                            cnt_d = '0;
                            if (sym_q == SYM_LAST) begin
                                state_d = ST_IDLE;
                                sym_d   = '0;
                            end else begin
                                state_d = ST_DATA_CP;
                                sym_d   = sym_q + 1'b1;
                            end
                        end else begin
                            cnt_d = cnt_q + cnt_t'(1);
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        sym_d   = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            sym_q    <= '0;
            resync_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sym_q    <= sym_d;
            resync_q <= resync_d;
        end
    end

`ifdef FRAMER_SYMBOL_INDEX_EN
    logic [3:0] fwd_user;

    always_comb begin
        fwd_user = 4'(LTF_SYMBOLS) + 4'(sym_q);
        if (state_q == ST_LTF) fwd_user = 4'(cnt_q >> $clog2(FFT_LEN));
    end
`endif

    axis_out_reg #(.DATA_W(SAMPLE_W)) u_out_reg (
        .clk_i   (s00_axis_aclk),
        .rst_n_i (s00_axis_aresetn),
        .load_i  (fwd),
        .data_i  (s00_axis_tdata),
        .last_i  (fwd_last),
`ifdef FRAMER_SYMBOL_INDEX_EN
        .user_i  (fwd_user),
`endif
        .m_if    (m_if)
    );

    assign m_if.tready     = m00_axis_tready;
    assign m00_axis_tvalid = m_if.tvalid;
    assign m00_axis_tdata  = m_if.tdata;
    assign m00_axis_tlast  = m_if.tlast;
`ifdef FRAMER_SYMBOL_INDEX_EN
    assign m00_axis_tuser  = m_if.tuser;
`endif

    assign busy         = (state_q != ST_IDLE);
    assign resync_pulse = resync_q;

endmodule

// File: tb/tb_ofdm_symbol_framer.sv
// Scoreboard bench for ofdm_symbol_framer: a 4-data-symbol and an LTF-only instance share one input stream.
`timescale 1ns/1ps
module tb_ofdm_symbol_framer;
    import csi_pkg::*;

    typedef struct packed {
        sample_t    d;
        logic       last;
        logic [3:0] user;
    } exp_t;

    logic    clk = 1'b0;
    always #5 clk = ~clk;

    logic    rst_n   = 1'b0;
    logic    s_valid = 1'b0;
    logic    s_user  = 1'b0;
    sample_t s_data  = '0;
    logic    m_ready = 1'b1;
    logic    rdy4, rdy0, busy4, busy0, rs4, rs0;

    ofdm_symbol_framer_if #(.DATA_W(32)) m4 ();
    ofdm_symbol_framer_if #(.DATA_W(32)) m0 ();
    assign m4.tready = m_ready;
    assign m0.tready = m_ready;

    ofdm_symbol_framer #(.NUM_DATA_SYMBOLS(4), .SAMPLE_W(32)) dut4 (
        .s00_axis_aclk(clk), .s00_axis_aresetn(rst_n), .s00_axis_tvalid(s_valid),
        .s00_axis_tdata(s_data), .s00_axis_tuser(s_user), .s00_axis_tready(rdy4),
        .m00_axis_tvalid(m4.tvalid), .m00_axis_tdata(m4.tdata), .m00_axis_tlast(m4.tlast),
        .m00_axis_tready(m4.tready),
`ifdef FRAMER_SYMBOL_INDEX_EN
        .m00_axis_tuser(m4.tuser),
`endif
        .busy(busy4), .resync_pulse(rs4));

    ofdm_symbol_framer #(.NUM_DATA_SYMBOLS(0), .SAMPLE_W(32)) dut0 (
        .s00_axis_aclk(clk), .s00_axis_aresetn(rst_n), .s00_axis_tvalid(s_valid),
        .s00_axis_tdata(s_data), .s00_axis_tuser(s_user), .s00_axis_tready(rdy0),
        .m00_axis_tvalid(m0.tvalid), .m00_axis_tdata(m0.tdata), .m00_axis_tlast(m0.tlast),
        .m00_axis_tready(m0.tready),
`ifdef FRAMER_SYMBOL_INDEX_EN
        .m00_axis_tuser(m0.tuser),
`endif
        .busy(busy0), .resync_pulse(rs0));

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model, index 0 = 4 data symbols, index 1 = LTF only.
    int  ndata[2]   = '{4, 0};
    int  pos[2]     = '{0, 0};
    bit  act[2]     = '{0, 0};
    bit  exp_rs[2]  = '{0, 0};
    bit  exp_fwd[2] = '{0, 0};
    int  fwd_cnt[2] = '{0, 0};
    int  out_n[2]   = '{0, 0};
    int  last_n[2]  = '{0, 0};
    exp_t    q4[$];
    exp_t    q0[$];
    sample_t log4[$];
    bit  post_reset = 1'b0;

    task automatic chk(input bit ok, input string name, input longint act_v, input longint exp_v);
        n_vec++;
        if (!ok) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act_v, exp_v, $time);
        end
    endtask

    // Position p counts beats since sync (sync = 0): GI 0..31, LTF 32..159, then 80-beat data periods.
    task automatic model_beat(input int i, input sample_t d, input bit u);
        int   p, q, sym, r;
        bit   f;
        exp_t e;
        f = 1'b0;
        e = '0;
        if (u) begin
            exp_rs[i] = act[i];
            act[i]    = 1'b1;
            pos[i]    = 1;
        end else if (act[i]) begin
            p = pos[i];
            if (p >= 32 && p < 160) begin
                f = 1'b1; e.d = d; e.last = ((p - 32) % 64 == 63); e.user = 4'((p - 32) / 64);
            end else if (p >= 160) begin
                q = p - 160; sym = q / 80; r = q % 80;
                if (r >= 16) begin
                    f = 1'b1; e.d = d; e.last = (r == 79); e.user = 4'(2 + sym);
                end
            end
            pos[i] = p + 1;
            if (pos[i] == 160 + 80 * ndata[i]) act[i] = 1'b0;
        end
        exp_fwd[i] = f;
        if (f) begin
            fwd_cnt[i]++;
            if (i == 0) q4.push_back(e);
            else        q0.push_back(e);
        end
    endtask

    task automatic check_regs();
        chk(busy4 == act[0], "n4_busy", busy4, act[0]);
        chk(busy0 == act[1], "n0_busy", busy0, act[1]);
        chk(rs4 == exp_rs[0], "n4_resync_pulse", rs4, exp_rs[0]);
        chk(rs0 == exp_rs[1], "n0_resync_pulse", rs0, exp_rs[1]);
        if (exp_fwd[0]) chk(m4.tvalid == 1'b1, "n4_latency_valid", m4.tvalid, 1);
        if (exp_fwd[1]) chk(m0.tvalid == 1'b1, "n0_latency_valid", m0.tvalid, 1);
    endtask

    task automatic cycle(input bit v, input sample_t d, input bit u, input bit mr, output bit acc4);
        bit a0, a1;
        @(posedge clk);
        #2;
        rst_n = 1'b1; s_valid = v; s_data = d; s_user = u; m_ready = mr;
        #1;
        check_regs();
        #1;
        if (post_reset) begin
            chk(rdy4 == 1'b1, "n4_ready_after_reset", rdy4, 1);
            chk(rdy0 == 1'b1, "n0_ready_after_reset", rdy0, 1);
            post_reset = 1'b0;
        end
        a0 = v && rdy4;
        a1 = v && rdy0;
        for (int i = 0; i < 2; i++) begin
            exp_rs[i] = 1'b0;
            exp_fwd[i] = 1'b0;
        end
        if (a0) model_beat(0, d, u);
        if (a1) model_beat(1, d, u);
        acc4 = a0;
    endtask

    task automatic clear_logs();
        log4.delete();
        for (int i = 0; i < 2; i++) begin
            out_n[i] = 0; last_n[i] = 0; fwd_cnt[i] = 0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0; s_valid = 1'b0;
        #1;
        chk(m4.tvalid == 1'b0, "n4_rst_tvalid", m4.tvalid, 0);
        chk(m4.tlast == 1'b0, "n4_rst_tlast", m4.tlast, 0);
        chk(m4.tdata == '0, "n4_rst_tdata", m4.tdata, 0);
        chk(busy4 == 1'b0, "n4_rst_busy", busy4, 0);
        chk(rs4 == 1'b0, "n4_rst_resync", rs4, 0);
        chk(m0.tvalid == 1'b0, "n0_rst_tvalid", m0.tvalid, 0);
        chk(m0.tdata == '0, "n0_rst_tdata", m0.tdata, 0);
        chk(busy0 == 1'b0, "n0_rst_busy", busy0, 0);
        for (int i = 0; i < 2; i++) begin
            act[i] = 1'b0; exp_rs[i] = 1'b0; exp_fwd[i] = 1'b0; pos[i] = 0;
        end
        q4.delete();
        q0.delete();
        repeat (2) @(posedge clk);
        post_reset = 1'b1;
    endtask

    task automatic drain();
        bit a;
        for (int k = 0; k < 12; k++) cycle(1'b0, '0, 1'b0, 1'b1, a);
        chk(q4.size() == 0, "n4_drain_empty", q4.size(), 0);
        chk(q0.size() == 0, "n0_drain_empty", q0.size(), 0);
    endtask

    task automatic chk_log(input int idx, input int exp_v, input string name);
        if (idx < log4.size()) chk(log4[idx] == sample_t'(exp_v), name, log4[idx], exp_v);
        else                   chk(1'b0, name, log4.size(), idx + 1);
    endtask

    task automatic frame_checks(input int s);
        chk_log(0, s + 32, "first_ltf_out");
        chk_log(127, s + 159, "last_ltf_out");
        chk_log(128, s + 176, "first_data_out");
        chk(out_n[0] == 384, "n4_out_count", out_n[0], 384);
        chk(last_n[0] == 6, "n4_tlast_count", last_n[0], 6);
        chk(out_n[1] == 128, "n0_out_count", out_n[1], 128);
        chk(last_n[1] == 2, "n0_tlast_count", last_n[1], 2);
    endtask

    // kind: 1 full frame, 2 resync mid-LTF, 3 reset at forwarded sample 30 then a fresh frame.
    task automatic run_ramp(input int kind, input int beats, input int mode, input int resync_at);
        int n, cyc, sync_at, reset_at;
        bit a, mr;
        n = 0; cyc = 0; sync_at = 100; reset_at = (kind == 3) ? 30 : -1;
        clear_logs();
        while (n < beats && cyc < 4 * beats) begin
            mr = (mode == 0) ? 1'b1 : (cyc % 2 == 0);
            cycle(1'b1, sample_t'(n), (n == sync_at) || (n == resync_at), mr, a);
            if (a) n++;
            cyc++;
            if (reset_at >= 0 && fwd_cnt[0] == reset_at) begin
                do_reset();
                clear_logs();
                reset_at = -1;
                sync_at = n + 5;
            end
        end
        if (n < beats) chk(1'b0, "ramp_beat_budget", n, beats);
        drain();
        if (kind == 1 || kind == 3) frame_checks(sync_at);
        if (kind == 2) begin
            chk_log(49, sync_at + 32 + 49, "pre_resync_out");
            chk_log(50, resync_at + 32, "post_resync_first_out");
            chk(out_n[0] == 50 + 384, "n4_resync_out_count", out_n[0], 434);
        end
    endtask

    task automatic mon(input int i);
        exp_t    e;
        sample_t d;
        logic    l;
        d = (i == 0) ? m4.tdata : m0.tdata;
        l = (i == 0) ? m4.tlast : m0.tlast;
        if ((i == 0 && q4.size() == 0) || (i == 1 && q0.size() == 0)) begin
            chk(1'b0, (i == 0) ? "n4_unexpected_out" : "n0_unexpected_out", d, 0);
        end else begin
            if (i == 0) e = q4.pop_front();
            else        e = q0.pop_front();
            chk(d == e.d, (i == 0) ? "n4_tdata" : "n0_tdata", d, e.d);
            chk(l == e.last, (i == 0) ? "n4_tlast" : "n0_tlast", l, e.last);
`ifdef FRAMER_SYMBOL_INDEX_EN
            begin
                logic [3:0] u;
                u = (i == 0) ? m4.tuser : m0.tuser;
                chk(u == e.user, (i == 0) ? "n4_tuser" : "n0_tuser", u, e.user);
            end
`endif
            out_n[i]++;
            if (l) last_n[i]++;
            if (i == 0) log4.push_back(d);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #6;
            if (m4.tvalid && m_ready) mon(0);
            if (m0.tvalid && m_ready) mon(1);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss + 1);
        $fatal(1);
    end

    initial begin
        bit a, v, u, mr;
        repeat (2) @(posedge clk);
        #3;
        chk(m4.tvalid == 1'b0, "n4_init_tvalid", m4.tvalid, 0);
        chk(m4.tlast == 1'b0, "n4_init_tlast", m4.tlast, 0);
        chk(m4.tdata == '0, "n4_init_tdata", m4.tdata, 0);
        chk(busy4 == 1'b0, "n4_init_busy", busy4, 0);
        chk(rs4 == 1'b0, "n4_init_resync", rs4, 0);
        chk(m0.tvalid == 1'b0, "n0_init_tvalid", m0.tvalid, 0);
        chk(busy0 == 1'b0, "n0_init_busy", busy0, 0);
        post_reset = 1'b1;

        run_ramp(1, 620, 0, -1);
        run_ramp(1, 620, 1, -1);
        run_ramp(2, 700, 0, 182);
        run_ramp(3, 720, 0, -1);

        for (int k = 0; k < 3000; k++) begin
            v  = ($urandom_range(0, 3) != 0);
            u  = (k == 5) || ($urandom_range(0, 599) == 0);
            mr = ($urandom_range(0, 3) != 0);
            cycle(v, sample_t'($urandom), u, mr, a);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
